pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage ARM core.
- Sequences the IF/ID and ID/EXE stage registers: generates freeze, flush and bubble controls from data hazards, taken branches and SRAM wait states.
- Sits beside the ID stage; consumes ID source fields plus EXE/MEM destination info; drives the freeze/flush inputs of all stage registers and the PC.
- Keeps a memory-wait FSM with timeout and a stall-cycle counter.

---
 rtl/pipe_hazard_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Hazard-controller handshake bundle: ID/EXE/MEM inputs and stage-control outputs.
interface pipe_hazard_if;
  logic [3:0] src1;
  logic [3:0] src2;
  logic       two_src;
  logic       use_src1;
  logic       exe_wb_en;
  logic [3:0] exe_dest;
  logic       exe_mem_r_en;
  logic       mem_wb_en;
  logic [3:0] mem_dest;
  logic       forward_en;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       freeze_if;
  logic       flush_if_id;
  logic       flush_id_exe;
  logic       freeze_all;
  logic       mem_err;
  logic [15:0] stall_cnt_unused;

  // Pipeline side driving hazard sources and consuming controls.
  modport master (
    output src1, src2, two_src, use_src1, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, forward_en, branch_taken, mem_req, mem_ready,
    input  freeze_if, flush_if_id, flush_id_exe, freeze_all, mem_err
  );

  // Controller side.
  modport slave (
    input  src1, src2, two_src, use_src1, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, forward_en, branch_taken, mem_req, mem_ready,
    output freeze_if, flush_if_id, flush_id_exe, freeze_all, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freeze/flush/bubble generation, SRAM wait FSM
// with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_if.slave     hif,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  localparam logic [7:0] TMO      = 8'(MEM_TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hz_nofwd, hz_fwd, hz, ms, abort, stall;

  // Hazard terms; the index compare is raw, so r15 is not special.
  always_comb begin
    hz_nofwd = (hif.use_src1 && ((hif.exe_wb_en && hif.src1 == hif.exe_dest) ||
                                 (hif.mem_wb_en && hif.src1 == hif.mem_dest))) ||
               (hif.two_src  && ((hif.exe_wb_en && hif.src2 == hif.exe_dest) ||
                                 (hif.mem_wb_en && hif.src2 == hif.mem_dest)));
    hz_fwd   = hif.exe_mem_r_en && ((hif.use_src1 && hif.src1 == hif.exe_dest) ||
                                    (hif.two_src  && hif.src2 == hif.exe_dest));
    hz       = hif.forward_en ? hz_fwd : hz_nofwd;
    ms       = hif.mem_req && !hif.mem_ready;
    // On timeout the stall is dropped for one cycle so the pipe can move on.
    abort    = (state_q == MEM_WAIT) && ms && (wait_cnt_q == TMO);
    stall    = ms && !abort;
  end

  // Priority-encoded stage controls, forced idle while reset is held.
  always_comb begin
    hif.freeze_if    = 1'b0;
    hif.flush_if_id  = 1'b0;
    hif.flush_id_exe = 1'b0;
    hif.freeze_all   = 1'b0;
    if (rst_n) begin
      if (stall) begin
        hif.freeze_all = 1'b1;
        hif.freeze_if  = 1'b1;
      end else if (hif.branch_taken) begin
        hif.flush_if_id  = 1'b1;
        hif.flush_id_exe = 1'b1;
      end else if (hz) begin
        hif.freeze_if    = 1'b1;
        hif.flush_id_exe = 1'b1;
      end
    end
  end

  // Memory-wait FSM next state, timeout detection and stall counting.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (ms) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      default: begin
        if (!ms) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else if (abort) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
    endcase
    if ((hif.freeze_if || hif.freeze_all) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers; reset drops any pending wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hif.mem_err  = mem_err_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue of expected control vectors.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [3:0] src1, src2;
    logic       two_src, use_src1, exe_wb_en;
    logic [3:0] exe_dest;
    logic       exe_mem_r_en, mem_wb_en;
    logic [3:0] mem_dest;
    logic       forward_en, branch_taken, mem_req, mem_ready;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] stall_cnt;
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];
  stim_t      s;

  always #5 clk = ~clk;

  pipe_hazard_if hif();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hif       (hif),
    .stall_cnt (stall_cnt)
  );

  // Controls packed as {freeze_if, flush_if_id, flush_id_exe, freeze_all}.
  task automatic apply(input string tag, input stim_t st, input logic [3:0] e);
    logic [3:0] got, exp;
    hif.src1 = st.src1;           hif.src2 = st.src2;
    hif.two_src = st.two_src;     hif.use_src1 = st.use_src1;
    hif.exe_wb_en = st.exe_wb_en; hif.exe_dest = st.exe_dest;
    hif.exe_mem_r_en = st.exe_mem_r_en;
    hif.mem_wb_en = st.mem_wb_en; hif.mem_dest = st.mem_dest;
    hif.forward_en = st.forward_en; hif.branch_taken = st.branch_taken;
    hif.mem_req = st.mem_req;     hif.mem_ready = st.mem_ready;
    exp_q.push_back(e);
    @(negedge clk);
    got = {hif.freeze_if, hif.flush_if_id, hif.flush_id_exe, hif.freeze_all};
    exp = exp_q.pop_front();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, got, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    // Reset with a live hazard on the inputs: controls must stay idle.
    s = '0; s.src1 = 4'd3; s.use_src1 = 1'b1; s.exe_wb_en = 1'b1; s.exe_dest = 4'd3;
    apply("reset_ctl", s, 4'b0000);
    chk("reset_cnt", 8'(stall_cnt), 8'd0);
    chk("reset_err", 8'(hif.mem_err), 8'd0);
    rst_n = 1'b1;

    // Forwarding off: EXE match, then MEM match, then src1 unused.
    apply("nofwd_exe", s, 4'b1010);
    s.exe_dest = 4'd5; s.mem_wb_en = 1'b1; s.mem_dest = 4'd3;
    apply("nofwd_mem", s, 4'b1010);
    s.use_src1 = 1'b0;
    apply("nofwd_unused", s, 4'b0000);
    chk("cnt_after_nofwd", 8'(stall_cnt), 8'd2);

    // Forwarding on: load-use on src2, then non-load.
    s = '0; s.forward_en = 1'b1; s.exe_mem_r_en = 1'b1; s.exe_wb_en = 1'b1;
    s.exe_dest = 4'd7; s.two_src = 1'b1; s.src2 = 4'd7;
    apply("fwd_load_use", s, 4'b1010);
    chk("cnt_inc1", 8'(stall_cnt), 8'd3);
    apply("fwd_load_use2", s, 4'b1010);
    chk("cnt_inc2", 8'(stall_cnt), 8'd4);
    s.exe_mem_r_en = 1'b0;
    apply("fwd_no_load", s, 4'b0000);

    // Branch beats a hazard.
    s = '0; s.src1 = 4'd3; s.use_src1 = 1'b1; s.exe_wb_en = 1'b1; s.exe_dest = 4'd3;
    s.branch_taken = 1'b1;
    apply("branch_over_hz", s, 4'b0110);
    chk("cnt_branch", 8'(stall_cnt), 8'd4);

    // r15 compared like any other register.
    s.branch_taken = 1'b0; s.src1 = 4'd15; s.exe_dest = 4'd15;
    apply("r15_hz", s, 4'b1010);

    // Memory stall masks branch and hazard for 4 cycles, then ready.
    s.branch_taken = 1'b1; s.mem_req = 1'b1; s.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply("mem_stall", s, 4'b1001);
    s = '0; s.mem_req = 1'b1; s.mem_ready = 1'b1;
    apply("mem_ready", s, 4'b0000);
    chk("cnt_mem", 8'(stall_cnt), 8'd9);
    chk("err_after_ready", 8'(hif.mem_err), 8'd0);

    // Timeout: 4 frozen cycles, release in the 5th, sticky error.
    s.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply("tmo_wait", s, 4'b1001);
    chk("err_before_tmo", 8'(hif.mem_err), 8'd0);
    apply("tmo_abort", s, 4'b0000);
    chk("err_set", 8'(hif.mem_err), 8'd1);
    chk("cnt_tmo", 8'(stall_cnt), 8'd13);
    apply("tmo_restall", s, 4'b1001);
    s.mem_ready = 1'b1;
    apply("tmo_ready", s, 4'b0000);
    s.mem_req = 1'b0;
    apply("tmo_idle", s, 4'b0000);
    chk("err_sticky", 8'(hif.mem_err), 8'd1);

    // Saturation at 15.
    s = '0; s.src1 = 4'd2; s.use_src1 = 1'b1; s.mem_wb_en = 1'b1; s.mem_dest = 4'd2;
    apply("sat_hz", s, 4'b1010);
    chk("cnt_sat1", 8'(stall_cnt), 8'd15);
    for (int i = 0; i < 5; i++) apply("sat_hz", s, 4'b1010);
    chk("cnt_sat2", 8'(stall_cnt), 8'd15);

    // Reset in the middle of a wait.
    s = '0; s.mem_req = 1'b1;
    apply("pre_rst_wait", s, 4'b1001);
    rst_n = 1'b0;
    apply("rst_mid_wait", s, 4'b0000);
    chk("rst_cnt", 8'(stall_cnt), 8'd0);
    chk("rst_err", 8'(hif.mem_err), 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply("post_rst_wait", s, 4'b1001);
    apply("post_rst_abort", s, 4'b0000);
    chk("post_rst_err", 8'(hif.mem_err), 8'd1);
    chk("post_rst_cnt", 8'(stall_cnt), 8'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
